// File: rtl/uart_tx_if.sv
// Byte handshake between a byte producer and the uart_tx serialiser.
// The producer offers tx_data/tx_valid; the serialiser reports tx_ready/tx_busy.
interface uart_tx_if;
    logic [7:0] tx_data;
    logic       tx_valid;
    logic       tx_ready;
    logic       tx_busy;

    modport master (
        output tx_data,
        output tx_valid,
        input  tx_ready,
        input  tx_busy
    );

    modport slave (
        input  tx_data,
        input  tx_valid,
        output tx_ready,
        output tx_busy
    );
endinterface

// File: rtl/uart_tx.sv
// UART transmitter: start bit, 8 data bits LSB first, optional even parity, 1 or 2 stop bits.
// Define UART_TX_PARITY_EN to insert the even-parity bit between data and stop.
module uart_tx #(
    parameter int unsigned CLK_DIV   = 868,
    parameter int unsigned STOP_BITS = 1
) (
    input  logic     clk,
    input  logic     reset,
    uart_tx_if.slave tx,
    output logic     UART_TX
);

    localparam int unsigned CNT_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(CLK_DIV - 1);
    localparam logic [2:0]       STOP_LAST = 3'(STOP_BITS - 1);

`ifdef UART_TX_PARITY_EN
    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;
`else
    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;
`endif

    state_t           state, state_next;
    logic [CNT_W-1:0] cnt, cnt_next;
    logic [2:0]       idx, idx_next;
    logic [7:0]       shreg, shreg_next;
    logic             line_next;
    logic             bit_done;
`ifdef UART_TX_PARITY_EN
    logic             par_q, par_next;
`endif

    assign tx.tx_ready = (state == IDLE) && !reset;
    assign tx.tx_busy  = (state != IDLE);
    assign bit_done    = (cnt == CNT_LAST);

    always_comb begin
        state_next = state;
        cnt_next   = cnt;
        idx_next   = idx;
        shreg_next = shreg;
        line_next  = 1'b1;
`ifdef UART_TX_PARITY_EN
        par_next   = par_q;
`endif
        case (state)
            IDLE: begin
                if (tx.tx_valid) begin
                    state_next = START;
                    shreg_next = tx.tx_data;
                    cnt_next   = '0;
                    idx_next   = '0;
`ifdef UART_TX_PARITY_EN
                    par_next   = ^tx.tx_data;
`endif
                end
            end
            START: begin
                if (bit_done) begin
                    state_next = DATA;
                    cnt_next   = '0;
                end else begin
                    cnt_next = cnt + 1'b1;
                end
            end
            DATA: begin
                if (bit_done) begin
                    cnt_next   = '0;
                    shreg_next = {1'b0, shreg[7:1]};
                    if (idx == 3'd7) begin
                        idx_next = '0;
`ifdef UART_TX_PARITY_EN
                        state_next = PARITY;
`else
                        state_next = STOP;
`endif
                    end else begin
                        idx_next = idx + 1'b1;
                    end
                end else begin
                    cnt_next = cnt + 1'b1;
                end
            end
`ifdef UART_TX_PARITY_EN
            PARITY: begin
                if (bit_done) begin
                    state_next = STOP;
                    cnt_next   = '0;
                end else begin
                    cnt_next = cnt + 1'b1;
                end
            end
`endif
            STOP: begin
                // idx is reused to count stop bits
                if (bit_done) begin
                    cnt_next = '0;
                    if (idx == STOP_LAST) begin
                        state_next = IDLE;
                        idx_next   = '0;
                    end else begin
                        idx_next = idx + 1'b1;
                    end
                end else begin
                    cnt_next = cnt + 1'b1;
                end
            end
            default: state_next = IDLE;
        endcase

        // The line register is loaded from the state being entered, so it changes on the same edge as the state.
        case (state_next)
            START:   line_next = 1'b0;
            DATA:    line_next = shreg_next[0];
`ifdef UART_TX_PARITY_EN
            PARITY:  line_next = par_q;
`endif
            default: line_next = 1'b1;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= IDLE;
            cnt     <= '0;
            idx     <= '0;
            shreg   <= '0;
            UART_TX <= 1'b1;
`ifdef UART_TX_PARITY_EN
            par_q   <= 1'b0;
`endif
        end else begin
            state   <= state_next;
            cnt     <= cnt_next;
            idx     <= idx_next;
            shreg   <= shreg_next;
            UART_TX <= line_next;
`ifdef UART_TX_PARITY_EN
            par_q   <= par_next;
`endif
        end
    end

endmodule

// File: doc/uart_tx.md
UART_TX -- requirements
Module: uart_tx

Interface
REQ-001 The block SHALL have parameter CLK_DIV, default 868, giving clk cycles per bit (100 MHz / 115200 baud); legal range 2..65535.
REQ-002 The block SHALL have parameter STOP_BITS, default 1, giving the number of stop bits; legal values 1 or 2.
REQ-003 The block SHALL have port clk, input, 1 bit: the single clock; all logic is on its rising edge.
REQ-004 The block SHALL have port reset, input, 1 bit: synchronous, active-high reset.
REQ-005 The block SHALL have port tx_data, input, 8 bits: the byte to send, sampled only on accept.
REQ-006 The block SHALL have port tx_valid, input, 1 bit: the byte on tx_data is offered.
REQ-007 The block SHALL have port tx_ready, output, 1 bit: the block can accept a byte this cycle.
REQ-008 The block SHALL have port tx_busy, output, 1 bit: a frame is in progress (any state other than IDLE).
REQ-009 The block SHALL have port UART_TX, output, 1 bit: the serial line, idle high, registered output.

Function
REQ-010 The block SHALL implement the states IDLE, START, DATA, PARITY (present only with the macro), and STOP.
REQ-011 In IDLE: UART_TX=1, tx_ready=1, tx_busy=0.
REQ-012 Accept SHALL occur in a cycle where tx_valid=1 and tx_ready=1; tx_data is captured into a shift register and the state moves to START.
REQ-013 UART_TX SHALL go low on the clk edge after accept (1-cycle latency).
REQ-014 Every bit (start, data, parity, stop) SHALL hold UART_TX for exactly CLK_DIV clk cycles, timed by a bit counter that reloads at each bit boundary.
REQ-015 Data bits SHALL be sent LSB first, bit 0 through bit 7; an internal 3-bit index counts 0..7 and leaves DATA after index 7 completes.
REQ-016 The STOP state SHALL drive UART_TX=1 for STOP_BITS*CLK_DIV cycles, then return to IDLE.
REQ-017 Frame length from the first start-bit cycle to the last stop cycle SHALL be (1+8+P+STOP_BITS)*CLK_DIV cycles, where P=1 with parity and P=0 without.
REQ-018 tx_ready SHALL be 0 in every non-IDLE state; tx_valid and tx_data SHALL be ignored while tx_ready=0.
REQ-019 Back-to-back: with tx_valid held high, the next accept SHALL occur in the first IDLE cycle after STOP, giving exactly 1 idle-high clk cycle between frames.
REQ-020 tx_data changes after accept SHALL NOT affect the frame in flight.
REQ-021 The bit counter SHALL be ceil(log2(CLK_DIV)) bits wide and SHALL never wrap mid-bit.

Reset
REQ-022 While reset=1: state=IDLE, UART_TX=1, tx_ready=0, tx_busy=0, counters=0, shift register=0.
REQ-023 In the first cycle after reset deasserts, tx_ready SHALL be 1.
REQ-024 Reset asserted mid-frame SHALL abort the frame and drive UART_TX=1 on the next edge; no partial bit may be resumed.
REQ-025 Reset SHALL take priority over a simultaneous accept.

Configuration
REQ-026 When the macro UART_TX_PARITY_EN is defined, the block SHALL insert a PARITY state after DATA that sends even parity (XOR of the 8 captured data bits) for CLK_DIV cycles before STOP.
REQ-027 When UART_TX_PARITY_EN is undefined, the block SHALL contain no PARITY state or logic, and DATA SHALL go directly to STOP (8N1 / 8N2).

Verification
REQ-028 The bench SHALL cover single byte: CLK_DIV=4, tx_data=8'hA5, one-cycle tx_valid -> UART_TX samples at bit centres are 0,1,0,1,0,0,1,0,1,1; tx_busy high for 40 cycles; tx_ready returns 1 after the frame.
REQ-029 The bench SHALL cover back-to-back: CLK_DIV=4, tx_valid held with bytes 8'h00 then 8'hFF -> two frames separated by exactly 1 idle-high cycle; the second frame has 8 high data bits.
REQ-030 The bench SHALL cover data ignored while busy: change tx_data to 8'h3C mid-frame of 8'hA5 -> the line still carries A5, and 3C is not accepted until tx_ready=1.
REQ-031 The bench SHALL cover reset mid-frame: assert reset during data bit 3 -> UART_TX=1 the next cycle and tx_ready=0 while reset is held; tx_ready=1 the cycle after release; the next byte 8'h55 is sent correctly.
REQ-032 The bench SHALL cover parity: with UART_TX_PARITY_EN, 8'h07 -> parity bit 1 and a 44-cycle frame at CLK_DIV=4; 8'h03 -> parity bit 0.
REQ-033 The bench SHALL cover the default baud: CLK_DIV=868, STOP_BITS=2, byte 8'h41 -> a loopback receiver at 115200 decodes 8'h41; frame length is 9548 cycles.
